seg7_frame_capture: RTL
=======================

// Module: seg7_frame_capture
// PURPOSE
//  Receive-side monitor for a 7-segment output bus, as driven by the animation display top.
//  Synchronises and glitch-filters the segment lines, accepts each new stable pattern as a frame,
//  decodes it to hex and measures its dwell time in clk cycles.
//  Frames are offered on a valid/ready port for on-chip self-check or readback via the bidir pins.
// PARAMETERS
//  STABLE_CYCLES  16  edges a pattern must hold unchanged before acceptance; legal range 2..255
//  PERIOD_BIT     25  width of the dwell/period counter; 25 covers >3 s at 10 MHz
// PORTS
//  clk             in   1           clock
//  reset           in   1           asynchronous, active-high reset
//  segments_i      in   7           segment bus; bit0=a .. bit6=g; active-high
//  frame_ready_i   in   1           consumer ready
//  clear_i         in   1           one-cycle pulse; clears overrun status
//  frame_valid_o   out  1           frame held for consumer
//  frame_seg_o     out  7           raw accepted pattern
//  frame_hex_o     out  4           decoded digit; 0 if pattern is not hex
//  frame_is_hex_o  out  1           pattern matched the hex table
//  frame_period_o  out  PERIOD_BIT  clk edges since previous accept
//  overrun_o       out  1           sticky; a frame was dropped
// BEHAVIOUR
//  - Reset: every output, sync flops, candidate, counters = 0; last_acc = 7'h00 (blank); state EMPTY.
//  - Synchroniser: 2-flop, s1 -> s2.
//  - Filter: if s2 != cand then cand <= s2 and scnt <= 0; else scnt saturates at STABLE_CYCLES-1.
//    Accept on an edge where s2 == cand, scnt == STABLE_CYCLES-1 and cand != last_acc.
//    Accept sets last_acc <= cand.
//  - Latency: frame_valid_o is high after edge STABLE_CYCLES+3, counting the edge that first
//    samples the new value into s1 as edge 1. Default is edge 19.
//  - Pattern revert before acceptance: no frame.
//  - Repeat of last_acc after a rejected glitch: no frame.
//  - Period counter pcnt:
//    - 0 at reset; +1 per edge, saturating at all-ones.
//    - On accept: frame_period_o <= pcnt+1 (saturating) and pcnt <= 0.
//    - Result: period = edges between consecutive accepts; first frame = edges since reset release.
//  - Decode table (hex: seg):
//    0:3F  1:06  2:5B  3:4F  4:66  5:6D  6:7D  7:07
//    8:7F  9:6F  A:77  b:7C  C:39  d:5E  E:79  F:71
//    Any other pattern: is_hex=0, hex=0.
//  - Output FSM:
//    - EMPTY: accept -> load outputs, FULL.
//    - FULL, valid&&ready, no accept -> EMPTY.
//    - FULL, valid&&ready, same-cycle accept -> load new frame, stay FULL.
//    - FULL, no handshake, accept -> frame dropped, held data unchanged, overrun_o <= 1,
//      last_acc still updates.
//  - frame_valid_o = (state == FULL). Outputs are stable while valid && !ready.
//  - clear_i -> overrun_o <= 0. A same-cycle overrun event wins.
//  - Reset mid-frame: immediate return to reset state; pending frame lost, not re-reported.
// CONFIGURATION
//  SEGCAP_OVERRUN_CNT_EN defined:
//    - Adds output overrun_cnt_o [7:0], reset 0.
//    - +1 per dropped frame, saturates at 255; cleared by clear_i; same-cycle drop -> value 1.
//  SEGCAP_OVERRUN_CNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Package seg7_cap_pkg: the 16 hex segment-code constants, FSM state enum
//    (ST_EMPTY, ST_FULL), blank code 7'h00.
//  - Sub-module seg7_hex_decode: combinational 7-bit -> {is_hex, hex[3:0]} lookup.
//    Top holds synchroniser, filter, period counter, FSM and output registers.
// TESTING
//  1. Reset; segments_i=7'h06 held 40 cyc, ready=0 -> valid high after edge 19;
//     seg=06, hex=1, is_hex=1. Ready=1 -> valid low next edge.
//  2. Stable 06 accepted; then 5B for 10 cyc, back to 06 -> no new valid, overrun_o=0.
//  3. Segments_i=7'h40 held 40 cyc -> valid, seg=40, is_hex=0, hex=0.
//  4. Ready=1; 06 then 5B applied 1000 cyc apart -> second frame period=1000, hex=2.
//  5. Ready=0; frames 06 then 4F -> held frame stays 06, overrun_o=1
//     (with _EN: overrun_cnt_o=1). Pulse clear_i -> 0.
//  6. Reset pulse while valid=1 -> all outputs 0. Segments_i=00 after release -> no frame;
//     then 06 -> frame with period = edges since release.

Source files
------------

// File: rtl/seg7_cap_pkg.sv
// Shared constants for the 7-segment frame capture block: hex segment codes and FSM states.
// Segment bit order is bit0=a .. bit6=g, active-high.
package seg7_cap_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational lookup from a 7-segment pattern to its hex digit.
// Patterns outside the table report is_hex=0 and hex=0.
module seg7_hex_decode
  import seg7_cap_pkg::*;
(
  input  logic [6:0] seg,
  output logic       is_hex,
  output logic [3:0] hex
);

  always_comb begin
    is_hex = 1'b1;
    hex    = 4'h0;
    case (seg)
      SEG_0:   hex = 4'h0;
      SEG_1:   hex = 4'h1;
      SEG_2:   hex = 4'h2;
      SEG_3:   hex = 4'h3;
      SEG_4:   hex = 4'h4;
      SEG_5:   hex = 4'h5;
      SEG_6:   hex = 4'h6;
      SEG_7:   hex = 4'h7;
      SEG_8:   hex = 4'h8;
      SEG_9:   hex = 4'h9;
      SEG_A:   hex = 4'hA;
      SEG_B:   hex = 4'hB;
      SEG_C:   hex = 4'hC;
      SEG_D:   hex = 4'hD;
      SEG_E:   hex = 4'hE;
      SEG_F:   hex = 4'hF;
      default: is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_frame_capture.sv
// Receive-side monitor for a 7-segment bus: synchronise, glitch-filter, decode, time and hand off frames.
// Define SEGCAP_OVERRUN_CNT_EN to add the saturating dropped-frame counter port overrun_cnt_o.
module seg7_frame_capture
  import seg7_cap_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int PERIOD_BIT    = 25
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            segments_i,
  input  logic                  frame_ready_i,
  input  logic                  clear_i,
  output logic                  frame_valid_o,
  output logic [6:0]            frame_seg_o,
  output logic [3:0]            frame_hex_o,
  output logic                  frame_is_hex_o,
  output logic [PERIOD_BIT-1:0] frame_period_o,
  output logic                  overrun_o
`ifdef SEGCAP_OVERRUN_CNT_EN
  ,
  output logic [7:0]            overrun_cnt_o
`endif
);

  localparam logic [7:0]            SCNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [PERIOD_BIT-1:0] PCNT_MAX = '1;

  logic [6:0]            s1_reg, s2_reg;
  logic [6:0]            cand_reg, last_acc_reg;
  logic [7:0]            scnt_reg;
  logic [PERIOD_BIT-1:0] pcnt_reg, pcnt_inc;
  state_t                state_reg, state_next;
  logic                  accept, load, drop;
  logic                  dec_is_hex;
  logic [3:0]            dec_hex;

  seg7_hex_decode u_decode (
    .seg    (cand_reg),
    .is_hex (dec_is_hex),
    .hex    (dec_hex)
  );

  // A pattern is accepted once it has been seen unchanged long enough and differs from the last one.
  assign accept   = (s2_reg == cand_reg) && (scnt_reg == SCNT_MAX) && (cand_reg != last_acc_reg);
  assign pcnt_inc = (pcnt_reg == PCNT_MAX) ? pcnt_reg : pcnt_reg + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_reg       <= SEG_BLANK;
      s2_reg       <= SEG_BLANK;
      cand_reg     <= SEG_BLANK;
      scnt_reg     <= '0;
      last_acc_reg <= SEG_BLANK;
      pcnt_reg     <= '0;
    end else begin
      s1_reg <= segments_i;
      s2_reg <= s1_reg;
      if (s2_reg != cand_reg) begin
        cand_reg <= s2_reg;
        scnt_reg <= '0;
      end else if (scnt_reg != SCNT_MAX) begin
        scnt_reg <= scnt_reg + 8'd1;
      end
      if (accept) begin
        last_acc_reg <= cand_reg;
        pcnt_reg     <= '0;
      end else begin
        pcnt_reg <= pcnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_EMPTY;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL:  if (!accept && frame_ready_i) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  // A frame arriving while the held one is still unclaimed is dropped.
  always_comb begin
    load = 1'b0;
    drop = 1'b0;
    case (state_reg)
      ST_EMPTY: load = accept;
      ST_FULL: begin
        load = accept && frame_ready_i;
        drop = accept && !frame_ready_i;
      end
      default: ;
    endcase
  end

  assign frame_valid_o = (state_reg == ST_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_seg_o    <= '0;
      frame_hex_o    <= '0;
      frame_is_hex_o <= 1'b0;
      frame_period_o <= '0;
    end else if (load) begin
      frame_seg_o    <= cand_reg;
      frame_hex_o    <= dec_hex;
      frame_is_hex_o <= dec_is_hex;
      frame_period_o <= pcnt_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        overrun_o <= 1'b0;
    else if (drop)    overrun_o <= 1'b1;
    else if (clear_i) overrun_o <= 1'b0;
  end

`ifdef SEGCAP_OVERRUN_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_cnt_o <= '0;
    end else if (drop) begin
      if (clear_i)                  overrun_cnt_o <= 8'd1;
      else if (overrun_cnt_o != '1) overrun_cnt_o <= overrun_cnt_o + 8'd1;
    end else if (clear_i) begin
      overrun_cnt_o <= '0;
    end
  end
`endif

endmodule
